// File: rtl/clock_pkg.sv
// Shared calendar constants and the date record used across the millennium clock.
package clock_pkg;
  localparam int BASE_YEAR       = 2025;
  localparam int YEAR_MAX        = 974;
  localparam int MONTHS_PER_YEAR = 12;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 10;

  localparam int RST_DAY   = 1;
  localparam int RST_MONTH = 1;
  localparam int RST_YEAR  = 0;

  typedef struct packed {
    logic [DAY_W-1:0]   day;
    logic [MONTH_W-1:0] month;
    logic [YEAR_W-1:0]  year;
  } date_t;
endpackage

// File: rtl/leap_year_check.sv
// Month-length lookup: returns days in (month, year offset) including the Gregorian leap rule.
module leap_year_check
  import clock_pkg::*;
(
  input  logic [5:0]        i_month,
  input  logic [YEAR_W-1:0] i_year,
  output logic [DAY_W-1:0]  o_max_day
);
  logic [11:0] w_full_year;
  logic        w_leap;

  assign w_full_year = 12'(BASE_YEAR) + {2'b00, i_year};
  assign w_leap = (w_full_year[1:0] == 2'b00) &&
                  (((w_full_year % 12'd100) != 12'd0) || ((w_full_year % 12'd400) == 12'd0));

  always_comb begin
    case (i_month)
      6'd2:                      o_max_day = w_leap ? 5'd29 : 5'd28;
      6'd4, 6'd6, 6'd9, 6'd11:   o_max_day = 5'd30;
      default:                   o_max_day = 5'd31;
    endcase
  end
endmodule

// File: rtl/date_counter.sv
// Calendar date register: advances one day per day_tick, accepts validated user loads.
module date_counter
  import clock_pkg::*;
#(
  parameter logic [YEAR_W-1:0]  YEAR_MAX  = YEAR_W'(clock_pkg::YEAR_MAX),
  parameter logic [DAY_W-1:0]   RST_DAY   = DAY_W'(clock_pkg::RST_DAY),
  parameter logic [MONTH_W-1:0] RST_MONTH = MONTH_W'(clock_pkg::RST_MONTH),
  parameter logic [YEAR_W-1:0]  RST_YEAR  = YEAR_W'(clock_pkg::RST_YEAR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               day_tick,
  input  logic               set_en,
  input  logic [DAY_W-1:0]   set_day,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [YEAR_W-1:0]  set_year,
  output logic [DAY_W-1:0]   day,
  output logic [MONTH_W-1:0] month,
  output logic [YEAR_W-1:0]  year,
  output logic               set_ack,
  output logic               set_err,
  output logic               month_roll,
  output logic               year_roll,
  output logic               wrap
);
  localparam logic [MONTH_W-1:0] LAST_MONTH = MONTH_W'(MONTHS_PER_YEAR);

  date_t            r_date;
  logic             r_set_ack, r_set_err, r_month_roll, r_year_roll, r_wrap;

  date_t            w_date_nxt;
  logic             w_ack_nxt, w_err_nxt, w_mroll_nxt, w_yroll_nxt, w_wrap_nxt;
  logic [DAY_W-1:0] w_cur_max, w_set_max;
  logic             w_set_ok;

  leap_year_check u_cur_len (
    .i_month   ({2'b00, r_date.month}),
    .i_year    (r_date.year),
    .o_max_day (w_cur_max)
  );

  leap_year_check u_set_len (
    .i_month   ({2'b00, set_month}),
    .i_year    (set_year),
    .o_max_day (w_set_max)
  );

  assign w_set_ok = (set_month != '0) && (set_month <= LAST_MONTH) &&
                    (set_day != '0) && (set_day <= w_set_max) &&
                    (set_year <= YEAR_MAX);

  // A set in the same cycle as a tick wins; the tick is dropped.
  always_comb begin
    w_date_nxt  = r_date;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_mroll_nxt = 1'b0;
    w_yroll_nxt = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (set_en) begin
      if (w_set_ok) begin
        w_date_nxt.day   = set_day;
        w_date_nxt.month = set_month;
        w_date_nxt.year  = set_year;
        w_ack_nxt        = 1'b1;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (day_tick) begin
      if (r_date.day < w_cur_max) begin
        w_date_nxt.day = r_date.day + 5'd1;
      end else begin
        // >= also pulls an out-of-range day back to the 1st.
        w_date_nxt.day = 5'd1;
        w_mroll_nxt    = 1'b1;
        if (r_date.month < LAST_MONTH) begin
          w_date_nxt.month = r_date.month + 4'd1;
        end else begin
          w_date_nxt.month = 4'd1;
          w_yroll_nxt      = 1'b1;
          if (r_date.year == YEAR_MAX) begin
            w_date_nxt.year = '0;
            w_wrap_nxt      = 1'b1;
          end else begin
            w_date_nxt.year = r_date.year + 10'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_date.day   <= RST_DAY;
      r_date.month <= RST_MONTH;
      r_date.year  <= RST_YEAR;
      r_set_ack    <= 1'b0;
      r_set_err    <= 1'b0;
      r_month_roll <= 1'b0;
      r_year_roll  <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_date       <= w_date_nxt;
      r_set_ack    <= w_ack_nxt;
      r_set_err    <= w_err_nxt;
      r_month_roll <= w_mroll_nxt;
      r_year_roll  <= w_yroll_nxt;
      r_wrap       <= w_wrap_nxt;
    end
  end

  assign day        = r_date.day;
  assign month      = r_date.month;
  assign year       = r_date.year;
  assign set_ack    = r_set_ack;
  assign set_err    = r_set_err;
  assign month_roll = r_month_roll;
  assign year_roll  = r_year_roll;
  assign wrap       = r_wrap;
endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: directed calendar cases plus random ticks/sets against a calendar model.
module tb_date_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       set_en = 1'b0;
  logic [4:0] set_day = '0;
  logic [3:0] set_month = '0;
  logic [9:0] set_year = '0;
  logic [4:0] day;
  logic [3:0] month;
  logic [9:0] year;
  logic       set_ack, set_err, month_roll, year_roll, wrap;

  int checks = 0;
  int errors = 0;

  int md, mm, my;
  bit e_ack, e_err, e_mroll, e_yroll, e_wrap;

  date_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .day_tick   (day_tick),
    .set_en     (set_en),
    .set_day    (set_day),
    .set_month  (set_month),
    .set_year   (set_year),
    .day        (day),
    .month      (month),
    .year       (year),
    .set_ack    (set_ack),
    .set_err    (set_err),
    .month_roll (month_roll),
    .year_roll  (year_roll),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  function automatic int mlen(int m, int y);
    int  fy;
    bit  leap;
    fy   = 2025 + y;
    leap = (fy % 4 == 0) && ((fy % 100 != 0) || (fy % 400 == 0));
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    md = 1; mm = 1; my = 0;
    e_ack = 0; e_err = 0; e_mroll = 0; e_yroll = 0; e_wrap = 0;
  endtask

  task automatic model_step(input bit tk, input bit se, input int sd, input int sm, input int sy);
    e_ack = 0; e_err = 0; e_mroll = 0; e_yroll = 0; e_wrap = 0;
    if (se) begin
      if (sm >= 1 && sm <= 12 && sd >= 1 && sy <= 974 && sd <= mlen(sm, sy)) begin
        md = sd; mm = sm; my = sy; e_ack = 1;
      end else begin
        e_err = 1;
      end
    end else if (tk) begin
      if (md >= mlen(mm, my)) begin
        md = 1; e_mroll = 1;
        if (mm == 12) begin
          mm = 1; e_yroll = 1;
          if (my == 974) begin my = 0; e_wrap = 1; end
          else my = my + 1;
        end else begin
          mm = mm + 1;
        end
      end else begin
        md = md + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".day"},   32'(day),        32'(md));
    chk({tag, ".month"}, 32'(month),      32'(mm));
    chk({tag, ".year"},  32'(year),       32'(my));
    chk({tag, ".ack"},   32'(set_ack),    32'(e_ack));
    chk({tag, ".err"},   32'(set_err),    32'(e_err));
    chk({tag, ".mroll"}, 32'(month_roll), 32'(e_mroll));
    chk({tag, ".yroll"}, 32'(year_roll),  32'(e_yroll));
    chk({tag, ".wrap"},  32'(wrap),       32'(e_wrap));
  endtask

  task automatic cyc(input string tag, input bit tk, input bit se,
                     input int sd, input int sm, input int sy);
    day_tick  = tk;
    set_en    = se;
    set_day   = 5'(sd);
    set_month = 4'(sm);
    set_year  = 10'(sy);
    model_step(tk, se, sd, sm, sy);
    @(posedge clk);
    #1;
    check_all(tag);
    day_tick = 1'b0;
    set_en   = 1'b0;
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #7;
    check_all("rst_hold");
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("idle");
    cyc("idle2", 1'b0, 1'b0, 0, 0, 0);

    // Mid-run async reset must take effect before the next clock edge.
    ticks("pre_rst", 6);
    chk("pre_rst_day", 32'(day), 32'd7);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1 rst_n = 1'b1;

    cyc("set_28_2_3", 1'b0, 1'b1, 28, 2, 3);
    cyc("leap_t1", 1'b1, 1'b0, 0, 0, 0);
    chk("leap_feb29", 32'(day), 32'd29);
    cyc("leap_t2", 1'b1, 1'b0, 0, 0, 0);
    chk("leap_mar1_roll", 32'(month_roll), 32'd1);
    cyc("leap_hold", 1'b0, 1'b0, 0, 0, 0);

    cyc("set_28_2_75", 1'b0, 1'b1, 28, 2, 75);
    cyc("c2100_t", 1'b1, 1'b0, 0, 0, 0);
    chk("c2100_month", 32'(month), 32'd3);
    cyc("set_29_2_75", 1'b0, 1'b1, 29, 2, 75);
    chk("c2100_err", 32'(set_err), 32'd1);
    cyc("set_29_2_375", 1'b0, 1'b1, 29, 2, 375);
    chk("c2400_ack", 32'(set_ack), 32'd1);

    cyc("set_31_4", 1'b0, 1'b1, 31, 4, 10);
    cyc("set_day0", 1'b0, 1'b1, 0, 5, 10);
    cyc("set_m13", 1'b0, 1'b1, 5, 13, 10);
    cyc("set_m0", 1'b0, 1'b1, 5, 0, 10);
    cyc("set_y975", 1'b0, 1'b1, 1, 1, 975);
    chk("bad_sets_day", 32'(day), 32'd29);

    cyc("set_31_12_974", 1'b0, 1'b1, 31, 12, 974);
    cyc("wrap_t", 1'b1, 1'b0, 0, 0, 0);
    chk("wrap_pulse", 32'(wrap), 32'd1);
    cyc("wrap_after", 1'b0, 1'b0, 0, 0, 0);
    cyc("set_31_12_5", 1'b0, 1'b1, 31, 12, 5);
    cyc("yroll_t", 1'b1, 1'b0, 0, 0, 0);
    chk("yroll_year", 32'(year), 32'd6);

    cyc("set_and_tick", 1'b1, 1'b1, 15, 6, 20);
    chk("set_tick_day", 32'(day), 32'd15);

    cyc("set_1_1_0", 1'b0, 1'b1, 1, 1, 0);
    ticks("ff2025", 365);
    chk("ff2025_year", 32'(year), 32'd1);
    chk("ff2025_day", 32'(day), 32'd1);
    cyc("set_1_1_3", 1'b0, 1'b1, 1, 1, 3);
    ticks("ff2028", 366);
    chk("ff2028_year", 32'(year), 32'd4);
    chk("ff2028_month", 32'(month), 32'd1);

    // Random mix of ticks and sets, biased toward month/year ends.
    for (int i = 0; i < 400; i++) begin
      bit tk, se;
      int sd, sm, sy;
      tk = ($urandom_range(0, 99) < 70);
      se = ($urandom_range(0, 99) < 12);
      sd = ($urandom_range(0, 1) == 1) ? $urandom_range(27, 31) : $urandom_range(0, 31);
      sm = ($urandom_range(0, 3) == 0) ? 12 : $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       sy = 974;
        1:       sy = $urandom_range(970, 1023);
        default: sy = $urandom_range(0, 974);
      endcase
      cyc("rand", tk, se, sd, sm, sy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
